adr_sequencer: RTL and testbench

//  Control-side driver of the address maker. Issues SEL codes, QUAD_inc and TOG_inc
//  so the address maker walks every pixel x 4 quadrants: read T, read G, write T, write G.

---
 rtl/adr_pkg.sv | 23 ++
 rtl/adr_sequencer.sv | 178 +++++++++++++++++
 tb/tb_adr_sequencer.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/adr_pkg.sv
// Shared address-source select codes and the adr_sequencer state encoding.
// Also used by the address maker, so the SEL codes must not be renumbered.
package adr_pkg;

  localparam logic [2:0] ADR_NONE = 3'd0;
  localparam logic [2:0] ADR_RT   = 3'd1;
  localparam logic [2:0] ADR_RG   = 3'd2;
  localparam logic [2:0] ADR_WT   = 3'd3;
  localparam logic [2:0] ADR_WG   = 3'd4;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_RD_T  = 4'd1,
    ST_RD_G  = 4'd2,
    ST_WAIT  = 4'd3,
    ST_WR_T  = 4'd4,
    ST_WR_G  = 4'd5,
    ST_QNEXT = 4'd6,
    ST_PNEXT = 4'd7,
    ST_DONE  = 4'd8
  } seq_state_e;

endpackage

// File: rtl/adr_sequencer.sv
// Walks every pixel through 4 quadrants of read T/G, wait, write T/G for the address maker.
// Optional quadrant-zero consistency check: define ADR_SEQ_QCHECK_EN.
module adr_sequencer
  import adr_pkg::*;
#(
  parameter int PIX_W    = 8,
  parameter int N_PIX    = 256,
  parameter int WAIT_CYC = 1
) (
  input  logic             in_Clock,
  input  logic             in_Reset_n,
  input  logic             start,
  input  logic             stall,
  input  logic             quad_z,
  output logic [PIX_W-1:0] A,
  output logic [2:0]       SEL,
  output logic             re,
  output logic             we,
  output logic             QUAD_inc,
  output logic             TOG_inc,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int WAIT_W = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_CYC - 1);
  localparam logic [PIX_W-1:0]  LAST_PIX  = PIX_W'(N_PIX - 1);

  seq_state_e        state_q, state_d;
  logic [PIX_W-1:0]  a_q, a_d;
  logic [1:0]        quad_q, quad_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  logic [2:0] sel_s;
  logic       re_s, we_s, qinc_s, tinc_s, busy_s, done_s;

  always_ff @(posedge in_Clock or negedge in_Reset_n) begin
    if (!in_Reset_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      quad_q  <= 2'd0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      quad_q  <= quad_d;
      wait_q  <= wait_d;
    end
  end

  // Outputs decode the registered state; only re/we also see stall so a stalled access is dropped.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    quad_d  = quad_q;
    wait_d  = wait_q;
    sel_s   = ADR_NONE;
    re_s    = 1'b0;
    we_s    = 1'b0;
    qinc_s  = 1'b0;
    tinc_s  = 1'b0;
    busy_s  = 1'b1;
    done_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy_s = 1'b0;
        if (start) state_d = ST_RD_T;
        else       state_d = ST_IDLE;
      end
      ST_RD_T: begin
        sel_s = ADR_RT;
        if (stall) begin
          state_d = ST_RD_T;
        end else begin
          re_s    = 1'b1;
          state_d = ST_RD_G;
        end
      end
      ST_RD_G: begin
        sel_s = ADR_RG;
        if (stall) begin
          state_d = ST_RD_G;
        end else begin
          re_s    = 1'b1;
          wait_d  = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (wait_q == WAIT_LAST) begin
          wait_d  = '0;
          state_d = ST_WR_T;
        end else begin
          wait_d  = wait_q + WAIT_W'(1);
          state_d = ST_WAIT;
        end
      end
      ST_WR_T: begin
        sel_s = ADR_WT;
        if (stall) begin
          state_d = ST_WR_T;
        end else begin
          we_s    = 1'b1;
          state_d = ST_WR_G;
        end
      end
      ST_WR_G: begin
        sel_s = ADR_WG;
        if (stall) begin
          state_d = ST_WR_G;
        end else begin
          we_s    = 1'b1;
          state_d = ST_QNEXT;
        end
      end
      ST_QNEXT: begin
        qinc_s = 1'b1;
        quad_d = quad_q + 2'd1;
        if (quad_q == 2'd3) state_d = ST_PNEXT;
        else                state_d = ST_RD_T;
      end
      ST_PNEXT: begin
        tinc_s = 1'b1;
        if (a_q == LAST_PIX) begin
          state_d = ST_DONE;
        end else begin
          a_d     = a_q + PIX_W'(1);
          state_d = ST_RD_T;
        end
      end
      ST_DONE: begin
        busy_s  = 1'b0;
        done_s  = 1'b1;
        a_d     = '0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_s  = 1'b0;
        a_d     = '0;
        quad_d  = 2'd0;
        wait_d  = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign A        = a_q;
  assign SEL      = sel_s;
  assign re       = re_s;
  assign we       = we_s;
  assign QUAD_inc = qinc_s;
  assign TOG_inc  = tinc_s;
  assign busy     = busy_s;
  assign done     = done_s;

`ifdef ADR_SEQ_QCHECK_EN
  logic err_q;

  // Sticky flag: the address maker's quadrant-zero view must agree with ours while in RD_T.
  always_ff @(posedge in_Clock or negedge in_Reset_n) begin
    if (!in_Reset_n) begin
      err_q <= 1'b0;
    end else if ((state_q == ST_RD_T) && (quad_z != (quad_q == 2'd0))) begin
      err_q <= 1'b1;
    end else begin
      err_q <= err_q;
    end
  end

  assign err = err_q;
`else
  logic unused_quad_z;
  assign unused_quad_z = quad_z;
  assign err           = 1'b0;
`endif

endmodule

// File: tb/tb_adr_sequencer.sv
// Self-checking bench for adr_sequencer: per-cycle expected outputs are built from a
// quadrant table, queued as stimulus is driven and compared when the cycle is sampled.
module tb_adr_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start, stall, quad_z;
  logic [7:0] A;
  logic [2:0] SEL;
  logic       re, we, QUAD_inc, TOG_inc, busy, done, err;

  logic       start256;
  logic [7:0] A256;
  logic [2:0] SEL256;
  logic       re256, we256, qi256, ti256, busy256, done256, err256;

  adr_sequencer #(.PIX_W(8), .N_PIX(2), .WAIT_CYC(1)) dut (
    .in_Clock(clk), .in_Reset_n(rst_n), .start(start), .stall(stall), .quad_z(quad_z),
    .A(A), .SEL(SEL), .re(re), .we(we), .QUAD_inc(QUAD_inc), .TOG_inc(TOG_inc),
    .busy(busy), .done(done), .err(err)
  );

  adr_sequencer #(.PIX_W(8), .N_PIX(256), .WAIT_CYC(1)) dut256 (
    .in_Clock(clk), .in_Reset_n(rst_n), .start(start256), .stall(1'b0), .quad_z(1'b1),
    .A(A256), .SEL(SEL256), .re(re256), .we(we256), .QUAD_inc(qi256), .TOG_inc(ti256),
    .busy(busy256), .done(done256), .err(err256)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef ADR_SEQ_QCHECK_EN
  localparam int EXP_ERR = 1;
`else
  localparam int EXP_ERR = 0;
`endif

  typedef struct packed {
    logic [2:0] sel;
    logic       re, we, qi, ti, busy, done;
    logic [7:0] a;
  } obs_t;

  typedef struct {
    string      name;
    logic [2:0] sel;
    logic       re, we, qi;
  } qvec_t;

  qvec_t qtab[6];
  obs_t  sb[$];
  int    n_vec, n_err, cyc, first_rd, done_cyc, n_qi, n_ti;

  task automatic chk(input string nm, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, want);
    end
  endtask

  task automatic drive_cycle(input bit st, input bit stl, input bit qz, input obs_t e, input string nm);
    obs_t got, want;
    @(posedge clk);
    #1;
    start  = st;
    stall  = stl;
    quad_z = qz;
    sb.push_back(e);
    @(negedge clk);
    cyc++;
    got  = {SEL, re, we, QUAD_inc, TOG_inc, busy, done, A};
    want = sb.pop_front();
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got sel=%0d re=%b we=%b qi=%b ti=%b busy=%b done=%b A=%0d, expected sel=%0d re=%b we=%b qi=%b ti=%b busy=%b done=%b A=%0d",
               nm, got.sel, got.re, got.we, got.qi, got.ti, got.busy, got.done, got.a,
               want.sel, want.re, want.we, want.qi, want.ti, want.busy, want.done, want.a);
    end
    if (re && first_rd < 0) first_rd = cyc;
    if (done) done_cyc = cyc;
    if (QUAD_inc) n_qi++;
    if (TOG_inc) n_ti++;
  endtask

  function automatic obs_t idle_obs();
    obs_t e;
    e = '0;
    return e;
  endfunction

  task automatic do_reset();
    obs_t got;
    start = 1'b0; stall = 1'b0; quad_z = 1'b1; start256 = 1'b0;
    rst_n = 1'b0;
    #1;
    got = {SEL, re, we, QUAD_inc, TOG_inc, busy, done, A};
    chk("reset_outputs", int'(got), 0);
    chk("reset_err", int'(err), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One N_PIX=2 frame; the knobs select stall/start/quad_z/abort corner cases.
  task automatic run_frame(input int stall_n, input bit stall_misc, input bit hold_start,
                           input int pulse_at, input int abort_pix, input bit force_qz);
    obs_t e;
    int   k;
    bit   st, stl, qz;
    first_rd = -1; done_cyc = -1; n_qi = 0; n_ti = 0; k = 0;
    drive_cycle(1'b1, stall_misc, 1'b1, idle_obs(), "idle_start");
    for (int p = 0; p < 2; p++) begin
      for (int q = 0; q < 4; q++) begin
        for (int i = 0; i < 6; i++) begin
          st = hold_start || (k == pulse_at);
          qz = (q == 0) && !(force_qz && p == 0);
          if (p == 0 && q == 0 && i == 3) begin
            for (int s = 0; s < stall_n; s++) begin
              e = '0; e.sel = 3'd3; e.busy = 1'b1; e.a = 8'(p);
              drive_cycle(st, 1'b1, qz, e, "wr_t_stalled");
            end
          end
          e = '0;
          e.sel = qtab[i].sel; e.re = qtab[i].re; e.we = qtab[i].we; e.qi = qtab[i].qi;
          e.busy = 1'b1; e.a = 8'(p);
          stl = stall_misc && (i == 2 || i == 5);
          drive_cycle(st, stl, qz, e, qtab[i].name);
          k++;
          if (abort_pix == p && q == 0 && i == 1) return;
        end
      end
      e = '0; e.ti = 1'b1; e.busy = 1'b1; e.a = 8'(p);
      drive_cycle(hold_start, stall_misc, 1'b1, e, "pnext");
    end
    e = '0; e.done = 1'b1; e.a = 8'd1;
    drive_cycle(hold_start, stall_misc, 1'b1, e, "done");
  endtask

  initial begin
    obs_t e;
    int   ntog, last_tog_a, last_tog_i, maxa, first256, done_i;

    qtab[0] = '{"rd_t",  3'd1, 1'b1, 1'b0, 1'b0};
    qtab[1] = '{"rd_g",  3'd2, 1'b1, 1'b0, 1'b0};
    qtab[2] = '{"wait",  3'd0, 1'b0, 1'b0, 1'b0};
    qtab[3] = '{"wr_t",  3'd3, 1'b0, 1'b1, 1'b0};
    qtab[4] = '{"wr_g",  3'd4, 1'b0, 1'b1, 1'b0};
    qtab[5] = '{"qnext", 3'd0, 1'b0, 1'b0, 1'b1};
    n_vec = 0; n_err = 0; cyc = 0;

    do_reset();
    drive_cycle(1'b0, 1'b0, 1'b1, idle_obs(), "idle_after_reset");

    // Plain frame
    run_frame(0, 1'b0, 1'b0, -1, -1, 1'b0);
    chk("frame_len", done_cyc - first_rd + 1, 51);
    chk("quad_inc_count", n_qi, 8);
    chk("tog_inc_count", n_ti, 2);
    chk("err_clean_frame", int'(err), 0);
    drive_cycle(1'b0, 1'b0, 1'b1, idle_obs(), "idle_a_cleared");

    // WR_T stalled for 3 cycles
    run_frame(3, 1'b0, 1'b0, -1, -1, 1'b0);
    chk("stall_frame_len", done_cyc - first_rd + 1, 54);
    chk("stall_quad_inc_count", n_qi, 8);

    // Mid-frame start pulse plus stall in states that ignore it
    run_frame(0, 1'b1, 1'b0, 10, -1, 1'b0);
    chk("restart_frame_len", done_cyc - first_rd + 1, 51);

    // start held through DONE: one IDLE cycle, then a new frame
    run_frame(0, 1'b0, 1'b1, -1, -1, 1'b0);
    drive_cycle(1'b1, 1'b0, 1'b1, idle_obs(), "idle_after_held_start");
    e = '0; e.sel = 3'd1; e.re = 1'b1; e.busy = 1'b1;
    drive_cycle(1'b0, 1'b0, 1'b1, e, "rd_t_new_frame");
    do_reset();

    // Asynchronous reset during RD_G of pixel 1
    run_frame(0, 1'b0, 1'b0, -1, 1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    e = {SEL, re, we, QUAD_inc, TOG_inc, busy, done, A};
    chk("async_reset_outputs", int'(e), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    done_cyc = -1; n_ti = 0;
    for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b0, 1'b1, idle_obs(), "idle_after_abort");
    chk("no_done_after_abort", done_cyc, -1);
    chk("no_tog_after_abort", n_ti, 0);

    // quad_z wrong at quadrant 0 of pixel 0
    run_frame(0, 1'b0, 1'b0, -1, -1, 1'b1);
    chk("qcheck_err", int'(err), EXP_ERR);
    drive_cycle(1'b0, 1'b0, 1'b1, idle_obs(), "idle_after_qcheck");
    chk("qcheck_err_sticky", int'(err), EXP_ERR);
    do_reset();

    // Full 256-pixel frame on the second instance
    @(posedge clk); #1 start256 = 1'b1;
    @(posedge clk); #1 start256 = 1'b0;
    ntog = 0; last_tog_a = -1; last_tog_i = -1; maxa = 0; first256 = -1; done_i = -1;
    for (int i = 0; i < 8000; i++) begin
      @(negedge clk);
      if (re256 && first256 < 0) first256 = i;
      if (ti256) begin ntog++; last_tog_a = int'(A256); last_tog_i = i; end
      if (int'(A256) > maxa) maxa = int'(A256);
      if (done256) begin done_i = i; break; end
    end
    chk("n256_done_seen", int'(done_i >= 0), 1);
    chk("n256_tog_count", ntog, 256);
    chk("n256_last_tog_a", last_tog_a, 255);
    chk("n256_max_a", maxa, 255);
    chk("n256_done_after_tog", done_i - last_tog_i, 1);
    chk("n256_frame_len", done_i - first256 + 1, 256 * 25 + 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
